// File: rtl/sm_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module  : sm_accumulator_if
//  Brief   : Start/operand/result handshake bundle for sm_accumulator.
//  Rev     : 1.0  initial release
// ============================================================================
interface sm_accumulator_if #(
  parameter int IN_WIDTH    = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int COUNT_WIDTH = 10
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] num_terms;
  logic                   in_valid;
  logic [IN_WIDTH-1:0]    in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_data;
  logic                   overflow;
  logic                   busy;

  modport master (
    output start, num_terms, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, overflow, busy
  );

  modport slave (
    input  start, num_terms, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, overflow, busy
  );
endinterface
`default_nettype wire

// File: rtl/sm_accumulator.sv
`default_nettype none
// ============================================================================
//  Module  : sm_accumulator
//  Brief   : Streaming sign-magnitude accumulator with magnitude saturation.
//            Optional macro SM_ACC_RELU_EN presents negative sums as +0.
//  Rev     : 1.0  initial release
// ============================================================================
module sm_accumulator #(
  parameter int IN_WIDTH    = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int COUNT_WIDTH = 10
) (
  input  wire logic            clk,
  input  wire logic            rst,
  sm_accumulator_if.slave      bus
);
  localparam int MAG_W = ACC_WIDTH - 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [MAG_W-1:0] MAG_MAX = '1;

  logic [1:0]             state_q, state_d;
  logic                   acc_neg_q, acc_neg_d;
  logic [MAG_W-1:0]       acc_mag_q, acc_mag_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic [MAG_W-1:0]       w_op_mag;
  logic                   w_op_neg;
  logic [MAG_W:0]         w_sum;
  logic [MAG_W-1:0]       w_res_mag;
  logic                   w_res_neg;
  logic                   w_sat;
  logic                   w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_neg_q  <= 1'b0;
      acc_mag_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_neg_q  <= acc_neg_d;
      acc_mag_q  <= acc_mag_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Sign-magnitude add; a -0 operand is folded to +0 so the result never holds -0.
  always_comb begin
    w_op_mag  = MAG_W'(bus.in_data[IN_WIDTH-2:0]);
    w_op_neg  = bus.in_data[IN_WIDTH-1] & (w_op_mag != '0);
    w_sum     = {1'b0, acc_mag_q} + {1'b0, w_op_mag};
    w_sat     = 1'b0;
    w_res_neg = acc_neg_q;
    w_res_mag = acc_mag_q;
    if (w_op_neg == acc_neg_q) begin
      if (w_sum[MAG_W]) begin
        w_res_mag = MAG_MAX;
        w_sat     = 1'b1;
      end else begin
        w_res_mag = w_sum[MAG_W-1:0];
      end
    end else if (acc_mag_q >= w_op_mag) begin
      w_res_mag = acc_mag_q - w_op_mag;
    end else begin
      w_res_mag = w_op_mag - acc_mag_q;
      w_res_neg = w_op_neg;
    end
    if (w_res_mag == '0) begin
      w_res_neg = 1'b0;
    end
  end

  assign w_accept = (state_q == S_ACCUM) & bus.in_valid;

  always_comb begin
    state_d    = state_q;
    acc_neg_d  = acc_neg_q;
    acc_mag_d  = acc_mag_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_neg_d  = 1'b0;
          acc_mag_d  = '0;
          overflow_d = 1'b0;
          count_d    = bus.num_terms;
          state_d    = (bus.num_terms == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          acc_neg_d  = w_res_neg;
          acc_mag_d  = w_res_mag;
          overflow_d = overflow_q | w_sat;
          count_d    = count_q - COUNT_WIDTH'(1);
          if (count_q == COUNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_ACCUM);
    bus.out_valid = (state_q == S_DONE);
    bus.busy      = (state_q != S_IDLE);
    bus.overflow  = overflow_q;
`ifdef SM_ACC_RELU_EN
    bus.out_data  = acc_neg_q ? '0 : {acc_neg_q, acc_mag_q};
`else
    bus.out_data  = {acc_neg_q, acc_mag_q};
`endif
  end
endmodule
`default_nettype wire

// File: tb/tb_sm_accumulator.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sm_accumulator
//  Brief   : Scoreboard bench for a 16/32 and an 8/8 sm_accumulator instance.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sm_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       sel = 1'b0;
  logic       start_d = 1'b0;
  logic [9:0] num_d = '0;
  logic       in_valid_d = 1'b0;
  logic [15:0] in_data_d = '0;
  logic       out_ready_d = 1'b1;
  bit         ready_mode = 1'b0;

  sm_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(32), .COUNT_WIDTH(10)) bus16 ();
  sm_accumulator_if #(.IN_WIDTH(8),  .ACC_WIDTH(8),  .COUNT_WIDTH(10)) bus8 ();

  sm_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .COUNT_WIDTH(10)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16));
  sm_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(8), .COUNT_WIDTH(10)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8));

  assign bus16.start     = start_d & ~sel;
  assign bus8.start      = start_d & sel;
  assign bus16.num_terms = num_d;
  assign bus8.num_terms  = num_d;
  assign bus16.in_valid  = in_valid_d & ~sel;
  assign bus8.in_valid   = in_valid_d & sel;
  assign bus16.in_data   = in_data_d;
  assign bus8.in_data    = in_data_d[7:0];
  assign bus16.out_ready = out_ready_d;
  assign bus8.out_ready  = out_ready_d;

  wire        w_in_ready  = sel ? bus8.in_ready  : bus16.in_ready;
  wire        w_out_valid = sel ? bus8.out_valid : bus16.out_valid;
  wire        w_busy      = sel ? bus8.busy      : bus16.busy;
  wire        w_overflow  = sel ? bus8.overflow  : bus16.overflow;
  wire [31:0] w_out_data  = sel ? {24'h0, bus8.out_data} : bus16.out_data;

  // Expected {overflow, data}; narrow results live in the low 8 bits.
  logic [32:0] q16[$];
  logic [32:0] q8[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: running signed integer sum, clamped to +/-(2^(accw-1)-1) after each term.
  function automatic logic [32:0] ref_result(input int inw, input int accw, input int ops[$]);
    longint maxm = (longint'(1) << (accw - 1)) - 1;
    longint mmask = (longint'(1) << (inw - 1)) - 1;
    longint v = 0;
    longint mag;
    longint enc;
    bit ovf = 1'b0;
    foreach (ops[i]) begin
      mag = longint'(ops[i]) & mmask;
      v = ((ops[i] >> (inw - 1)) & 1) != 0 ? v - mag : v + mag;
      if (v > maxm) begin v = maxm; ovf = 1'b1; end
      else if (v < -maxm) begin v = -maxm; ovf = 1'b1; end
    end
`ifdef SM_ACC_RELU_EN
    if (v < 0) v = 0;
`endif
    enc = (v < 0) ? ((longint'(1) << (accw - 1)) | -v) : v;
    return {ovf, enc[31:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus16.out_valid) begin
      if (q16.size() == 0) check("out16_unexpected", 32'(q16.size()), 32'd1);
      else begin
        check("out16_data", bus16.out_data, q16[0][31:0]);
        check("out16_ovf", 32'(bus16.overflow), 32'(q16[0][32]));
        if (bus16.out_ready) void'(q16.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus8.out_valid) begin
      if (q8.size() == 0) check("out8_unexpected", 32'(q8.size()), 32'd1);
      else begin
        check("out8_data", {24'h0, bus8.out_data}, q8[0][31:0]);
        check("out8_ovf", 32'(bus8.overflow), 32'(q8[0][32]));
        if (bus8.out_ready) void'(q8.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode) out_ready_d = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_idle(input string name);
    int budget = 0;
    while (w_busy && budget < 400) begin
      @(posedge clk); #1;
      budget++;
    end
    if (w_busy) check(name, 32'(w_busy), 32'd0);
  endtask

  task automatic run(input bit s, input int ops[$], input bit hold, input int abort_after);
    int n = ops.size();
    int idx = 0;
    int budget = 0;
    logic [32:0] exp;
    wait_idle("idle_before_run");
    sel = s;
    exp = s ? ref_result(8, 8, ops) : ref_result(16, 32, ops);
    if (s) q8.push_back(exp); else q16.push_back(exp);
    start_d = 1'b1;
    num_d   = 10'(n);
    @(posedge clk); #1;
    start_d = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      check("zero_latency", 32'(w_out_valid), 32'd1);
      check("zero_in_ready", 32'(w_in_ready), 32'd0);
    end else begin
      while (idx < n && budget < 2000) begin
        in_valid_d = ($urandom_range(0, 3) != 0);
        in_data_d  = in_valid_d ? 16'(ops[idx]) : 16'($urandom);
        @(negedge clk);
        if (in_valid_d && w_in_ready) idx++;
        @(posedge clk); #1;
        budget++;
        if (abort_after >= 0 && idx == abort_after) break;
      end
      in_valid_d = 1'b0;
      if (idx < n && abort_after < 0) check("accept_timeout", 32'(idx), 32'(n));
      if (abort_after >= 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (s) void'(q8.pop_back()); else void'(q16.pop_back());
        @(negedge clk);
        check("rst_in_ready", 32'(w_in_ready), 32'd0);
        check("rst_out_valid", 32'(w_out_valid), 32'd0);
        check("rst_out_data", w_out_data, 32'd0);
        check("rst_overflow", 32'(w_overflow), 32'd0);
        check("rst_busy", 32'(w_busy), 32'd0);
        return;
      end
      @(negedge clk);
      check("last_term_latency", 32'(w_out_valid), 32'd1);
    end
    if (hold) begin
      repeat (5) begin
        @(posedge clk); #1;
        start_d = 1'($urandom_range(0, 1));
        num_d   = 10'($urandom_range(0, 1023));
      end
      start_d = 1'b0;
      out_ready_d = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_release_busy", 32'(w_busy), 32'd0);
      check("hold_release_valid", 32'(w_out_valid), 32'd0);
    end
    wait_idle("idle_after_run");
  endtask

  initial begin
    int ops[$];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(w_in_ready), 32'd0);
    check("reset_out_valid", 32'(w_out_valid), 32'd0);
    check("reset_out_data", w_out_data, 32'd0);
    check("reset_overflow", 32'(w_overflow), 32'd0);
    check("reset_busy", 32'(w_busy), 32'd0);
    @(posedge clk); #1;

    ops = '{32'h0005, 32'h8007, 32'h0001};  run(1'b0, ops, 1'b0, -1);
    ops = '{32'h0009, 32'h8009};            run(1'b0, ops, 1'b0, -1);
    ops = '{32'h0002, 32'h8005};            run(1'b0, ops, 1'b0, -1);
    ops = '{32'h8000, 32'h0003};            run(1'b0, ops, 1'b0, -1);
    ops = {};                               run(1'b0, ops, 1'b0, -1);
    out_ready_d = 1'b0;
    ops = '{32'h8123, 32'h0011, 32'h7FFF};  run(1'b0, ops, 1'b1, -1);
    ops = '{32'h0100, 32'h0200, 32'h0300, 32'h0400};
    run(1'b0, ops, 1'b0, 2);
    ops = '{32'h0010, 32'h8004, 32'h0001, 32'h0002};
    run(1'b0, ops, 1'b0, -1);

    ready_mode = 1'b1;
    for (int r = 0; r < 30; r++) begin
      int n = (r % 10 == 9) ? 40 : $urandom_range(0, 12);
      ops = {};
      for (int k = 0; k < n; k++) ops.push_back(int'($urandom_range(0, 65535)));
      run(1'b0, ops, 1'b0, -1);
    end

    ops = '{32'h64, 32'h64, 32'hE4};        run(1'b1, ops, 1'b0, -1);
    ops = '{32'hFF, 32'hFF, 32'h7F, 32'h01}; run(1'b1, ops, 1'b0, -1);
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(0, 8);
      ops = {};
      for (int k = 0; k < n; k++) ops.push_back(int'($urandom_range(0, 255)));
      run(1'b1, ops, 1'b0, -1);
    end

    ready_mode = 1'b0;
    out_ready_d = 1'b1;
    repeat (3) @(posedge clk);
    check("q16_drained", 32'(q16.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
